// File: rtl/wb_port_arbiter.sv
// Round-robin share of one scoreboard writeback port among NrReq FUs, each buffered by a DEPTH-entry FIFO.
// Optional macro WB_ARB_EX_PRIO_EN: heads carrying an exception win (lowest index) without moving the RR pointer.
module wb_port_arbiter #(
  parameter int unsigned NrReq       = 3,
  parameter int unsigned TransIdBits = 3,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic [NrReq-1:0]               req_valid_i,
  output logic [NrReq-1:0]               req_ready_o,
  input  logic [NrReq*TransIdBits-1:0]   req_trans_id_i,
  input  logic [NrReq*XLEN-1:0]          req_data_i,
  input  logic [NrReq-1:0]               req_ex_valid_i,
  output logic                           wb_valid_o,
  output logic [TransIdBits-1:0]         wb_trans_id_o,
  output logic [XLEN-1:0]                wb_data_o,
  output logic                           wb_ex_valid_o,
  output logic [$clog2(NrReq)-1:0]       wb_src_o,
  output logic                           busy_o
);

  localparam int unsigned SrcW = $clog2(NrReq);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [NrReq-1:0]       w_non_empty;
  logic [NrReq-1:0]       w_push;
  logic [NrReq-1:0]       w_pop;
  logic [NrReq-1:0]       w_head_ex;
  logic [TransIdBits-1:0] w_head_tid  [NrReq];
  logic [XLEN-1:0]        w_head_data [NrReq];

  logic [SrcW-1:0]        r_rr;
  logic [SrcW-1:0]        w_grant;
  logic [SrcW-1:0]        w_rr_grant;
  logic [SrcW-1:0]        w_ex_idx;
  logic [SrcW:0]          w_idx;
  logic                   w_rr_found;
  logic                   w_ex_grant;

  for (genvar gi = 0; gi < NrReq; gi++) begin : g_req
    logic [CntW-1:0]        r_cnt;
    logic [PtrW-1:0]        r_rptr;
    logic [PtrW-1:0]        r_wptr;
    logic [TransIdBits-1:0] r_tid_mem  [DEPTH];
    logic [XLEN-1:0]        r_data_mem [DEPTH];
    logic [DEPTH-1:0]       r_ex_mem;

    // Ready looks only at the registered count: a full FIFO stays not-ready even while popped.
    assign req_ready_o[gi] = (r_cnt != CntW'(DEPTH));
    assign w_non_empty[gi] = (r_cnt != '0);
    assign w_push[gi]      = req_valid_i[gi] && req_ready_o[gi] && !flush_i;
    assign w_pop[gi]       = wb_valid_o && (w_grant == SrcW'(gi));
    assign w_head_tid[gi]  = r_tid_mem[r_rptr];
    assign w_head_data[gi] = r_data_mem[r_rptr];
    assign w_head_ex[gi]   = r_ex_mem[r_rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt  <= '0;
        r_rptr <= '0;
        r_wptr <= '0;
      end else if (flush_i) begin
        r_cnt  <= '0;
        r_rptr <= '0;
        r_wptr <= '0;
      end else begin
        if (w_push[gi]) r_wptr <= r_wptr + PtrW'(1);
        if (w_pop[gi])  r_rptr <= r_rptr + PtrW'(1);
        if (w_push[gi] && !w_pop[gi])      r_cnt <= r_cnt + CntW'(1);
        else if (w_pop[gi] && !w_push[gi]) r_cnt <= r_cnt - CntW'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (w_push[gi]) begin
        r_tid_mem[r_wptr]  <= req_trans_id_i[gi*TransIdBits +: TransIdBits];
        r_data_mem[r_wptr] <= req_data_i[gi*XLEN +: XLEN];
        r_ex_mem[r_wptr]   <= req_ex_valid_i[gi];
      end
    end
  end

  always_comb begin
    w_rr_grant = '0;
    w_rr_found = 1'b0;
    w_idx      = '0;
    for (int k = 0; k < NrReq; k++) begin
      w_idx = {1'b0, r_rr} + (SrcW+1)'(k);
      if (w_idx >= (SrcW+1)'(NrReq)) w_idx = w_idx - (SrcW+1)'(NrReq);
      if (!w_rr_found && w_non_empty[w_idx[SrcW-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_grant = w_idx[SrcW-1:0];
      end
    end
  end

  always_comb begin
    w_ex_grant = 1'b0;
    w_ex_idx   = '0;
`ifdef WB_ARB_EX_PRIO_EN
    for (int k = NrReq - 1; k >= 0; k--) begin
      if (w_non_empty[k] && w_head_ex[k]) begin
        w_ex_grant = 1'b1;
        w_ex_idx   = SrcW'(k);
      end
    end
`else
    w_ex_grant = 1'b0;
    w_ex_idx   = '0;
`endif
  end

  assign w_grant    = w_ex_grant ? w_ex_idx : w_rr_grant;
  assign wb_valid_o = (|w_non_empty) && !flush_i;
  assign busy_o     = |w_non_empty;

  always_comb begin
    wb_trans_id_o = '0;
    wb_data_o     = '0;
    wb_ex_valid_o = 1'b0;
    wb_src_o      = '0;
    if (wb_valid_o) begin
      wb_trans_id_o = w_head_tid[w_grant];
      wb_data_o     = w_head_data[w_grant];
      wb_ex_valid_o = w_head_ex[w_grant];
      wb_src_o      = w_grant;
    end
  end

  // Exception-priority grants leave the round-robin pointer where it was.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr <= '0;
    end else if (flush_i) begin
      r_rr <= '0;
    end else if (wb_valid_o && !w_ex_grant) begin
      r_rr <= (w_grant == SrcW'(NrReq - 1)) ? '0 : w_grant + SrcW'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected writebacks queued at stimulus time, popped as they appear.
module tb_wb_port_arbiter;

  typedef struct packed {
    logic [1:0]  src;
    logic [2:0]  tid;
    logic        ex;
    logic [63:0] data;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         flush_i;
  logic [2:0]   req_valid_i;
  logic [2:0]   req_ready_o;
  logic [8:0]   req_trans_id_i;
  logic [191:0] req_data_i;
  logic [2:0]   req_ex_valid_i;
  logic         wb_valid_o;
  logic [2:0]   wb_trans_id_o;
  logic [63:0]  wb_data_o;
  logic         wb_ex_valid_o;
  logic [1:0]   wb_src_o;
  logic         busy_o;

  int   vectors = 0;
  int   errs    = 0;
  exp_t q[$];

  wb_port_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_trans_id_i(req_trans_id_i), .req_data_i(req_data_i),
    .req_ex_valid_i(req_ex_valid_i),
    .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o),
    .wb_data_o(wb_data_o), .wb_ex_valid_o(wb_ex_valid_o),
    .wb_src_o(wb_src_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] dat(input int s, input logic [2:0] id);
    return {16'hCAFE, s[15:0], 29'h0, id};
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_req();
    req_valid_i    = '0;
    req_ex_valid_i = '0;
    req_trans_id_i = '0;
    req_data_i     = '0;
  endtask

  task automatic set_req(input int i, input logic [2:0] id, input logic ex);
    req_valid_i[i]            = 1'b1;
    req_ex_valid_i[i]         = ex;
    req_trans_id_i[i*3 +: 3]  = id;
    req_data_i[i*64 +: 64]    = dat(i, id);
  endtask

  task automatic push_exp(input int i, input logic [2:0] id, input logic ex);
    exp_t e;
    e.src  = 2'(i);
    e.tid  = id;
    e.ex   = ex;
    e.data = dat(i, id);
    q.push_back(e);
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    clear_req();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    vectors++;
    if (wb_valid_o !== 1'b0 || wb_ex_valid_o !== 1'b0 || busy_o !== 1'b0 || wb_src_o !== 2'd0) begin
      errs++;
      $display("FAIL reset_out: got valid=%0b ex=%0b busy=%0b src=%0d, want 0 0 0 0",
               wb_valid_o, wb_ex_valid_o, busy_o, wb_src_o);
    end
    vectors++;
    if (req_ready_o !== 3'b111) begin
      errs++;
      $display("FAIL reset_ready: got %b, want 111", req_ready_o);
    end
    rst_ni = 1'b1;
    next_cycle();
    @(negedge clk_i);
    vectors++;
    if (wb_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 3'b111) begin
      errs++;
      $display("FAIL idle_after_reset: got valid=%0b busy=%0b ready=%b, want 0 0 111",
               wb_valid_o, busy_o, req_ready_o);
    end
  endtask

  task automatic test_round_robin();
    exp_t e, o;
    next_cycle();
    set_req(0, 3'd1, 1'b0); set_req(1, 3'd2, 1'b0); set_req(2, 3'd3, 1'b0);
    push_exp(0, 3'd1, 1'b0); push_exp(1, 3'd2, 1'b0); push_exp(2, 3'd3, 1'b0);
    @(negedge clk_i);
    vectors++;
    if (wb_valid_o !== 1'b0) begin
      errs++;
      $display("FAIL rr_no_bypass: got valid=%0b, want 0", wb_valid_o);
    end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      clear_req();
      @(negedge clk_i);
      vectors++;
      o = {wb_src_o, wb_trans_id_o, wb_ex_valid_o, wb_data_o};
      if (q.size() == 0) begin
        errs++;
        $display("FAIL rr_out: got valid=%0b id=%0d with nothing expected", wb_valid_o, wb_trans_id_o);
      end else begin
        e = q.pop_front();
        if (wb_valid_o !== 1'b1 || o !== e) begin
          errs++;
          $display("FAIL rr_out: got v=%0b src=%0d id=%0d ex=%0b data=%h, want v=1 src=%0d id=%0d ex=%0b data=%h",
                   wb_valid_o, o.src, o.tid, o.ex, o.data, e.src, e.tid, e.ex, e.data);
        end
      end
    end
    next_cycle();
    @(negedge clk_i);
    vectors++;
    if (wb_valid_o !== 1'b0 || busy_o !== 1'b0 || wb_data_o !== 64'h0 || wb_src_o !== 2'd0) begin
      errs++;
      $display("FAIL rr_idle: got valid=%0b busy=%0b src=%0d data=%h, want all 0",
               wb_valid_o, busy_o, wb_src_o, wb_data_o);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    next_cycle();
    set_req(0, 3'd0, 1'b0); set_req(1, 3'd4, 1'b0);
    push_exp(0, 3'd0, 1'b0); push_exp(1, 3'd4, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      clear_req();
      case (c)
        1: begin set_req(1, 3'd5, 1'b0); push_exp(1, 3'd5, 1'b0); end
        2: set_req(1, 3'd6, 1'b0);
        3: begin set_req(1, 3'd6, 1'b0); push_exp(1, 3'd6, 1'b0); end
        default: ;
      endcase
      @(negedge clk_i);
      if (c == 2 || c == 3) begin
        vectors++;
        if (req_ready_o[1] !== (c == 3)) begin
          errs++;
          $display("FAIL b2b_ready c%0d: got %0b, want %0b", c, req_ready_o[1], (c == 3));
        end
      end
      vectors++;
      o = {wb_src_o, wb_trans_id_o, wb_ex_valid_o, wb_data_o};
      if (q.size() == 0) begin
        errs++;
        $display("FAIL b2b_out: got valid=%0b id=%0d with nothing expected", wb_valid_o, wb_trans_id_o);
      end else begin
        e = q.pop_front();
        if (wb_valid_o !== 1'b1 || o !== e) begin
          errs++;
          $display("FAIL b2b_out c%0d: got v=%0b src=%0d id=%0d data=%h, want v=1 src=%0d id=%0d data=%h",
                   c, wb_valid_o, o.src, o.tid, o.data, e.src, e.tid, e.data);
        end
      end
    end
    next_cycle();
    clear_req();
    @(negedge clk_i);
    vectors++;
    if (wb_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 3'b111) begin
      errs++;
      $display("FAIL b2b_idle: got valid=%0b busy=%0b ready=%b, want 0 0 111", wb_valid_o, busy_o, req_ready_o);
    end
  endtask

  task automatic test_wrap();
    exp_t e, o;
    next_cycle();
    set_req(0, 3'd1, 1'b0);
    push_exp(0, 3'd1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      clear_req();
      if (c == 1) begin
        set_req(0, 3'd2, 1'b0); set_req(1, 3'd3, 1'b0); set_req(2, 3'd4, 1'b0);
        push_exp(1, 3'd3, 1'b0); push_exp(2, 3'd4, 1'b0); push_exp(0, 3'd2, 1'b0);
      end
      @(negedge clk_i);
      vectors++;
      o = {wb_src_o, wb_trans_id_o, wb_ex_valid_o, wb_data_o};
      if (q.size() == 0) begin
        errs++;
        $display("FAIL wrap_out: got valid=%0b id=%0d with nothing expected", wb_valid_o, wb_trans_id_o);
      end else begin
        e = q.pop_front();
        if (wb_valid_o !== 1'b1 || o !== e) begin
          errs++;
          $display("FAIL wrap_out c%0d: got v=%0b src=%0d id=%0d data=%h, want v=1 src=%0d id=%0d data=%h",
                   c, wb_valid_o, o.src, o.tid, o.data, e.src, e.tid, e.data);
        end
      end
    end
  endtask

  task automatic test_flush();
    exp_t e, o;
    next_cycle();
    clear_req();
    set_req(0, 3'd2, 1'b0); set_req(2, 3'd3, 1'b0);
    next_cycle();
    clear_req();
    set_req(1, 3'd5, 1'b0);
    flush_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (wb_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errs++;
      $display("FAIL flush_same_cycle: got valid=%0b busy=%0b, want 0 1", wb_valid_o, busy_o);
    end
    next_cycle();
    clear_req();
    flush_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (wb_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 3'b111 || wb_trans_id_o !== 3'd0) begin
      errs++;
      $display("FAIL flush_next: got valid=%0b busy=%0b ready=%b id=%0d, want 0 0 111 0",
               wb_valid_o, busy_o, req_ready_o, wb_trans_id_o);
    end
    next_cycle();
    set_req(0, 3'd1, 1'b0); set_req(1, 3'd2, 1'b0); set_req(2, 3'd3, 1'b0);
    push_exp(0, 3'd1, 1'b0); push_exp(1, 3'd2, 1'b0); push_exp(2, 3'd3, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      clear_req();
      @(negedge clk_i);
      vectors++;
      o = {wb_src_o, wb_trans_id_o, wb_ex_valid_o, wb_data_o};
      if (q.size() == 0) begin
        errs++;
        $display("FAIL flush_rr_out: got valid=%0b id=%0d with nothing expected", wb_valid_o, wb_trans_id_o);
      end else begin
        e = q.pop_front();
        if (wb_valid_o !== 1'b1 || o !== e) begin
          errs++;
          $display("FAIL flush_rr_out c%0d: got v=%0b src=%0d id=%0d, want v=1 src=%0d id=%0d",
                   c, wb_valid_o, o.src, o.tid, e.src, e.tid);
        end
      end
    end
  endtask

  task automatic test_ex_prio();
    exp_t e, o;
    next_cycle();
    set_req(0, 3'd6, 1'b0); set_req(2, 3'd7, 1'b1);
`ifdef WB_ARB_EX_PRIO_EN
    push_exp(2, 3'd7, 1'b1); push_exp(0, 3'd6, 1'b0);
`else
    push_exp(0, 3'd6, 1'b0); push_exp(2, 3'd7, 1'b1);
`endif
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      clear_req();
      @(negedge clk_i);
      vectors++;
      o = {wb_src_o, wb_trans_id_o, wb_ex_valid_o, wb_data_o};
      if (q.size() == 0) begin
        errs++;
        $display("FAIL ex_out: got valid=%0b id=%0d with nothing expected", wb_valid_o, wb_trans_id_o);
      end else begin
        e = q.pop_front();
        if (wb_valid_o !== 1'b1 || o !== e) begin
          errs++;
          $display("FAIL ex_out c%0d: got v=%0b src=%0d id=%0d ex=%0b, want v=1 src=%0d id=%0d ex=%0b",
                   c, wb_valid_o, o.src, o.tid, o.ex, e.src, e.tid, e.ex);
        end
      end
    end
    next_cycle();
    @(negedge clk_i);
    vectors++;
    if (wb_valid_o !== 1'b0 || wb_ex_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errs++;
      $display("FAIL ex_idle: got valid=%0b ex=%0b busy=%0b, want 0 0 0", wb_valid_o, wb_ex_valid_o, busy_o);
    end
  endtask

  task automatic test_mid_reset();
    next_cycle();
    set_req(0, 3'd1, 1'b0); set_req(1, 3'd2, 1'b0);
    next_cycle();
    clear_req();
    #1;
    rst_ni = 1'b0;
    #1;
    vectors++;
    if (wb_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 3'b111 || wb_src_o !== 2'd0) begin
      errs++;
      $display("FAIL mid_reset: got valid=%0b busy=%0b ready=%b src=%0d, want 0 0 111 0",
               wb_valid_o, busy_o, req_ready_o, wb_src_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    next_cycle();
    @(negedge clk_i);
    vectors++;
    if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset_after: got valid=%0b busy=%0b, want 0 0", wb_valid_o, busy_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_ex_prio();
    test_mid_reset();
    vectors++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_empty: got %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
